// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle of the EX stage's pipeline-facing signals.
//   ID/EX side   : flush, in_* instruction fields and register-file data
//   Forwarding   : mem_fwd_* and wb_fwd_* write-back candidates
//   EX/MEM side  : stall (combinational) and the registered out_* fields
// master drives the instruction/forwarding inputs; slave is the EX stage.
interface ex_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_use_imm;
    logic [4:0]  in_rd_addr;
    logic [6:0]  in_funct7;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        stall;
    logic        out_valid;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;

    modport master (
        output flush, in_valid, in_use_imm, in_rd_addr, in_funct7, in_funct3, in_imm,
               in_rs1_data, in_rs2_data, in_pc, in_rs1_addr, in_rs2_addr,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        input  stall, out_valid, out_rd_addr, out_result, out_store_data, out_pc
    );

    modport slave (
        input  flush, in_valid, in_use_imm, in_rd_addr, in_funct7, in_funct3, in_imm,
               in_rs1_data, in_rs2_data, in_pc, in_rs1_addr, in_rs2_addr,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
        output stall, out_valid, out_rd_addr, out_result, out_store_data, out_pc
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage. Resolves MEM/WB forwarding, computes the RV32I ALU
// result and registers it into the EX/MEM output fields.
// Ports: clk, reset (async, active-high), bus (ex_stage_if.slave: ID/EX fields,
// forwarding candidates, stall, out_* EX/MEM register).
// Build option EX_MDU_EN: when defined, an iterative radix-2 RV32M unit is built
// (33 stall cycles per M-op); when undefined, funct7=0x01 ops return 0 in one cycle.
module ex_stage (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    logic [31:0] rs1_fwd, rs2_fwd, op1, op2, alu_result;
    logic        is_mop, alu_fire;
    logic        done_valid;
    logic [4:0]  done_rd;
    logic [31:0] done_result, done_store, done_pc;

    // MEM has priority over WB; x0 is never forwarded.
    always_comb begin
        rs1_fwd = bus.in_rs1_data;
        if (bus.in_rs1_addr != 5'd0) begin
            if (bus.mem_fwd_en && bus.mem_fwd_rd == bus.in_rs1_addr) begin
                rs1_fwd = bus.mem_fwd_data;
            end else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.in_rs1_addr) begin
                rs1_fwd = bus.wb_fwd_data;
            end
        end
        rs2_fwd = bus.in_rs2_data;
        if (bus.in_rs2_addr != 5'd0) begin
            if (bus.mem_fwd_en && bus.mem_fwd_rd == bus.in_rs2_addr) begin
                rs2_fwd = bus.mem_fwd_data;
            end else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.in_rs2_addr) begin
                rs2_fwd = bus.wb_fwd_data;
            end
        end
    end

    assign op1    = rs1_fwd;
    assign op2    = bus.in_use_imm ? bus.in_imm : rs2_fwd;
    assign is_mop = bus.in_valid && !bus.in_use_imm && bus.in_funct7 == 7'h01;

    always_comb begin
        alu_result = '0;
        unique case (bus.in_funct3)
            3'b000: begin
                if (!bus.in_use_imm && bus.in_funct7 == 7'h20) alu_result = op1 - op2;
                else                                          alu_result = op1 + op2;
            end
            3'b001: alu_result = op1 << op2[4:0];
            3'b010: alu_result = {31'd0, $signed(op1) < $signed(op2)};
            3'b011: alu_result = {31'd0, op1 < op2};
            3'b100: alu_result = op1 ^ op2;
            3'b101: begin
                // Kept as separate statements so >>> stays in a signed context.
                if (bus.in_funct7[5]) alu_result = $signed(op1) >>> op2[4:0];
                else                  alu_result = op1 >> op2[4:0];
            end
            3'b110: alu_result = op1 | op2;
            3'b111: alu_result = op1 & op2;
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MDU_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        start, stall_c;
    logic [4:0]  count_q;
    logic [2:0]  funct3_q;
    logic [31:0] hi_q, lo_q, mag_q, dividend_q, pc_q, store_q;
    logic [4:0]  rd_q;
    logic        neg_q, rem_neg_q, div_zero_q;
    logic        a_signed, b_signed;
    logic [31:0] op1_mag, op2_mag;
    logic [32:0] mul_sum, div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] prod;
    logic [31:0] mdu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mop) begin
                    state_d = StBusy;
                    start   = 1'b1;
                    stall_c = 1'b1;
                end
            end
            StBusy: begin
                stall_c = 1'b1;
                if (count_q == 5'd31) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d = StIdle;
            start   = 1'b0;
            stall_c = 1'b0;
        end
    end

    assign bus.stall = stall_c && !reset;

    // Signedness per op: MULH both, MULHSU rs1 only, DIV/REM both, the rest none.
    always_comb begin
        if (bus.in_funct3[2]) begin
            a_signed = !bus.in_funct3[0];
            b_signed = !bus.in_funct3[0];
        end else begin
            a_signed = bus.in_funct3[1:0] == 2'b01 || bus.in_funct3[1:0] == 2'b10;
            b_signed = bus.in_funct3[1:0] == 2'b01;
        end
        op1_mag = (a_signed && op1[31]) ? -op1 : op1;
        op2_mag = (b_signed && op2[31]) ? -op2 : op2;
    end

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
    // Divide: {hi,lo} shifts left, lo starts as the dividend and collects quotient bits.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : 33'd0);
    assign div_shift = {hi_q, lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mag_q};
    assign div_diff  = div_shift[31:0] - mag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            funct3_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mag_q      <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            store_q    <= '0;
        end else if (start) begin
            count_q    <= '0;
            funct3_q   <= bus.in_funct3;
            hi_q       <= '0;
            lo_q       <= bus.in_funct3[2] ? op1_mag : op2_mag;
            mag_q      <= bus.in_funct3[2] ? op2_mag : op1_mag;
            dividend_q <= op1;
            neg_q      <= (a_signed && op1[31]) ^ (b_signed && op2[31]);
            rem_neg_q  <= a_signed && op1[31];
            div_zero_q <= op2 == 32'd0;
            rd_q       <= bus.in_rd_addr;
            pc_q       <= bus.in_pc;
            store_q    <= rs2_fwd;
        end else if (state_q == StBusy) begin
            count_q <= count_q + 5'd1;
            if (funct3_q[2]) begin
                hi_q <= div_ge ? div_diff : div_shift[31:0];
                lo_q <= {lo_q[30:0], div_ge};
            end else begin
                hi_q <= mul_sum[32:1];
                lo_q <= {mul_sum[0], lo_q[31:1]};
            end
        end
    end

    assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        if (funct3_q[2]) begin
            if (funct3_q[1]) begin
                if (div_zero_q) mdu_result = dividend_q;
                else            mdu_result = rem_neg_q ? -hi_q : hi_q;
            end else begin
                if (div_zero_q) mdu_result = 32'hFFFF_FFFF;
                else            mdu_result = neg_q ? -lo_q : lo_q;
            end
        end else begin
            mdu_result = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end
    end

    assign alu_fire    = bus.in_valid && state_q == StIdle && !is_mop;
    assign done_valid  = state_q == StDone;
    assign done_rd     = rd_q;
    assign done_result = mdu_result;
    assign done_store  = store_q;
    assign done_pc     = pc_q;
`else
    assign bus.stall   = 1'b0;
    assign alu_fire    = bus.in_valid;
    assign done_valid  = 1'b0;
    assign done_rd     = '0;
    assign done_result = '0;
    assign done_store  = '0;
    assign done_pc     = '0;
`endif

    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_result_q, out_result_d, out_store_q, out_store_d, out_pc_q, out_pc_d;

    // Anything that is not a finished op is a fully zeroed bubble.
    always_comb begin
        out_valid_d  = 1'b0;
        out_rd_d     = '0;
        out_result_d = '0;
        out_store_d  = '0;
        out_pc_d     = '0;
        if (!bus.flush) begin
            if (done_valid) begin
                out_valid_d  = 1'b1;
                out_rd_d     = done_rd;
                out_result_d = done_result;
                out_store_d  = done_store;
                out_pc_d     = done_pc;
            end else if (alu_fire) begin
                out_valid_d  = 1'b1;
                out_rd_d     = bus.in_rd_addr;
                out_result_d = is_mop ? 32'd0 : alu_result;
                out_store_d  = rs2_fwd;
                out_pc_d     = bus.in_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_rd_q     <= '0;
            out_result_q <= '0;
            out_store_q  <= '0;
            out_pc_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_rd_q     <= out_rd_d;
            out_result_q <= out_result_d;
            out_store_q  <= out_store_d;
            out_pc_q     <= out_pc_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_rd_addr    = out_rd_q;
    assign bus.out_result     = out_result_q;
    assign bus.out_store_data = out_store_q;
    assign bus.out_pc         = out_pc_q;
endmodule
